// File: rtl/atm_pin_pkg.sv
// Shared types and constants for the ATM PIN-entry front end: FSM states,
// key codes and PIN geometry.
package atm_pin_pkg;

  localparam int PIN_W       = 4;
  localparam int KEY_W       = 3;
  localparam int DIGIT_CNT_W = 3;

  localparam logic [DIGIT_CNT_W-1:0] PIN_FULL = DIGIT_CNT_W'(PIN_W);

  localparam logic [KEY_W-1:0] ZERO   = 3'd0;
  localparam logic [KEY_W-1:0] ONE    = 3'd1;
  localparam logic [KEY_W-1:0] CLEAR  = 3'd2;
  localparam logic [KEY_W-1:0] ENTER  = 3'd3;
  localparam logic [KEY_W-1:0] CANCEL = 3'd4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    COLLECT     = 3'd1,
    WAIT_RESULT = 3'd2,
    DONE        = 3'd3,
    LOCKED      = 3'd4
  } pin_state_t;

  // Only ZERO and ONE carry a PIN bit; the bit value is the LSB of the code.
  function automatic logic is_digit_key(input logic [KEY_W-1:0] code);
    return (code == ZERO) || (code == ONE);
  endfunction

endpackage

// File: rtl/atm_pin_entry_if.sv
// Keypad/card/result bundle between the ATM front panel side and the PIN-entry
// block; master drives keys and card/result status, slave is the PIN-entry block.
interface atm_pin_entry_if;
  import atm_pin_pkg::*;

  logic                   in_card;
  logic                   key_valid;
  logic [KEY_W-1:0]       key_code;
  logic                   pin_accept;
  logic                   pin_reject;
  logic [PIN_W-1:0]       out_PIN;
  logic                   pin_valid;
  logic [DIGIT_CNT_W-1:0] digit_cnt;
  logic                   O_Lockout;
  logic                   O_Timeout;
  logic                   eject_card;

  modport master (
    output in_card, key_valid, key_code, pin_accept, pin_reject,
    input  out_PIN, pin_valid, digit_cnt, O_Lockout, O_Timeout, eject_card
  );

  modport slave (
    input  in_card, key_valid, key_code, pin_accept, pin_reject,
    output out_PIN, pin_valid, digit_cnt, O_Lockout, O_Timeout, eject_card
  );

endinterface

// File: rtl/atm_timeout_counter.sv
// Inactivity counter: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1.
module atm_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // A clear in the terminal cycle wins, so a key arriving just in time restarts the count.
  assign expired = enable && !clear && (count == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/atm_pin_entry.sv
// PIN-entry front end: collects a 4-bit PIN from the keypad, hands it to the
// ATM FSM, tracks rejected attempts and handles inactivity timeout and lockout.
module atm_pin_entry
  import atm_pin_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_TRIES      = 3
) (
  input  logic           clk,
  input  logic           rst,
  atm_pin_entry_if.slave bus
);

  localparam int               TRY_W   = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

  pin_state_t             state;
  logic [PIN_W-1:0]       pin_buf;
  logic [PIN_W-1:0]       pin_out;
  logic [DIGIT_CNT_W-1:0] digit_cnt_q;
  logic [TRY_W-1:0]       try_cnt;
  logic [TRY_W-1:0]       try_inc;
  logic                   pin_valid_q;
  logic                   lockout_q;
  logic                   timeout_q;
  logic                   eject_q;
  logic                   tmo_clear;
  logic                   tmo_enable;
  logic                   tmo_expired;

  assign try_inc = try_cnt + TRY_W'(1);

  // The idle count runs only while collecting, holds while awaiting a verdict,
  // and is zeroed everywhere else so each COLLECT entry from IDLE starts fresh.
  assign tmo_enable = (state == COLLECT);
  assign tmo_clear  = (state == COLLECT) ? bus.key_valid : (state != WAIT_RESULT);

  atm_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pin_buf     <= '0;
      pin_out     <= '0;
      digit_cnt_q <= '0;
      try_cnt     <= '0;
      pin_valid_q <= 1'b0;
      lockout_q   <= 1'b0;
      timeout_q   <= 1'b0;
      eject_q     <= 1'b0;
    end else begin
      pin_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      eject_q     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.in_card) begin
            state       <= COLLECT;
            pin_buf     <= '0;
            pin_out     <= '0;
            digit_cnt_q <= '0;
            try_cnt     <= '0;
          end
        end

        COLLECT: begin
          // Card removal outranks any key or timeout and never ejects.
          if (!bus.in_card) begin
            state       <= IDLE;
            pin_buf     <= '0;
            digit_cnt_q <= '0;
          end else if (bus.key_valid) begin
            if (is_digit_key(bus.key_code)) begin
              if (digit_cnt_q < PIN_FULL) begin
                pin_buf     <= {pin_buf[PIN_W-2:0], bus.key_code[0]};
                digit_cnt_q <= digit_cnt_q + DIGIT_CNT_W'(1);
              end
            end else begin
              case (bus.key_code)
                CLEAR: begin
                  pin_buf     <= '0;
                  digit_cnt_q <= '0;
                end
                ENTER: begin
                  if (digit_cnt_q == PIN_FULL) begin
                    pin_out     <= pin_buf;
                    pin_valid_q <= 1'b1;
                    state       <= WAIT_RESULT;
                  end
                end
                CANCEL: begin
                  eject_q     <= 1'b1;
                  state       <= IDLE;
                  pin_buf     <= '0;
                  digit_cnt_q <= '0;
                end
                default: ;
              endcase
            end
          end else if (tmo_expired) begin
            timeout_q   <= 1'b1;
            eject_q     <= 1'b1;
            state       <= IDLE;
            pin_buf     <= '0;
            digit_cnt_q <= '0;
          end
        end

        WAIT_RESULT: begin
          if (!bus.in_card) begin
            state       <= IDLE;
            pin_buf     <= '0;
            digit_cnt_q <= '0;
          end else if (bus.pin_accept) begin
            state <= DONE;
          end else if (bus.pin_reject) begin
            try_cnt     <= try_inc;
            pin_buf     <= '0;
            digit_cnt_q <= '0;
            if (try_inc == TRY_MAX) begin
              state     <= LOCKED;
              lockout_q <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end

        DONE: begin
          if (!bus.in_card) begin
            state <= IDLE;
          end
        end

        // Card is retained; only reset leaves this state.
        LOCKED: begin
          lockout_q <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_PIN    = pin_out;
  assign bus.pin_valid  = pin_valid_q;
  assign bus.digit_cnt  = digit_cnt_q;
  assign bus.O_Lockout  = lockout_q;
  assign bus.O_Timeout  = timeout_q;
  assign bus.eject_card = eject_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Directed bench for atm_pin_entry: PINs pushed to a scoreboard at ENTER and
// compared when pin_valid appears; pulse widths watched on every cycle.
module tb_atm_pin_entry;
  import atm_pin_pkg::*;

  logic clk_tb = 1'b0;
  logic rst;

  always #5 clk_tb = ~clk_tb;

  atm_pin_entry_if bus ();

  atm_pin_entry #(
    .TIMEOUT_CYCLES(1000),
    .MAX_TRIES     (3)
  ) dut (
    .clk(clk_tb),
    .rst(rst),
    .bus(bus)
  );

  int         n_vec     = 0;
  int         n_err     = 0;
  int         eject_cnt = 0;
  int         tmo_cnt   = 0;
  int         e0;
  logic [3:0] exp_q[$];
  logic [3:0] pins[3];
  logic       pv_d = 1'b0;
  logic       ej_d = 1'b0;
  logic       to_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_tb);
    #1;
  endtask

  task automatic press(input logic [2:0] k);
    bus.key_code  = k;
    bus.key_valid = 1'b1;
    tick(1);
    bus.key_valid = 1'b0;
    bus.key_code  = 3'd7;
  endtask

  task automatic enter_pin(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) press({2'b00, p[i]});
  endtask

  // Scoreboard consumer and single-cycle pulse watch.
  always @(negedge clk_tb) begin
    if (rst) begin
      if (bus.pin_valid) begin
        check("pin_valid_one_cycle", 32'(pv_d), 32'd0);
        if (exp_q.size() > 0) check("out_PIN", 32'(bus.out_PIN), 32'(exp_q.pop_front()));
        else check("pin_valid_unexpected", 32'(bus.pin_valid), 32'd0);
      end
      if (bus.eject_card) begin
        eject_cnt++;
        check("eject_one_cycle", 32'(ej_d), 32'd0);
      end
      if (bus.O_Timeout) begin
        tmo_cnt++;
        check("timeout_one_cycle", 32'(to_d), 32'd0);
      end
    end
    pv_d = bus.pin_valid;
    ej_d = bus.eject_card;
    to_d = bus.O_Timeout;
  end

  initial begin
    rst            = 1'b0;
    bus.in_card    = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 3'd7;
    bus.pin_accept = 1'b0;
    bus.pin_reject = 1'b0;
    pins[0] = 4'b1011;
    pins[1] = 4'b0100;
    pins[2] = 4'b0001;

    // Reset state, with the card already inserted.
    tick(3);
    bus.in_card = 1'b1;
    tick(1);
    check("rst_out_PIN",   32'(bus.out_PIN),    32'd0);
    check("rst_pin_valid", 32'(bus.pin_valid),  32'd0);
    check("rst_digit_cnt", 32'(bus.digit_cnt),  32'd0);
    check("rst_lockout",   32'(bus.O_Lockout),  32'd0);
    check("rst_timeout",   32'(bus.O_Timeout),  32'd0);
    check("rst_eject",     32'(bus.eject_card), 32'd0);
    check("rst_state",     32'(dut.state),      32'(IDLE));
    rst = 1'b1;
    #2;
    check("release_no_edge_state", 32'(dut.state), 32'(IDLE));
    tick(1);
    check("release_first_edge_state", 32'(dut.state), 32'(COLLECT));

    // 1111 accepted, DONE holds the PIN, card out returns to IDLE.
    enter_pin(4'b1111);
    check("t1_digit_cnt", 32'(bus.digit_cnt), 32'd4);
    exp_q.push_back(4'b1111);
    press(ENTER);
    check("t1_pin_valid", 32'(bus.pin_valid), 32'd1);
    check("t1_state_wait", 32'(dut.state), 32'(WAIT_RESULT));
    press(ONE);
    check("t1_pin_valid_drop", 32'(bus.pin_valid), 32'd0);
    check("t1_wait_key_ignored", 32'(bus.digit_cnt), 32'd4);
    bus.pin_accept = 1'b1;
    tick(1);
    bus.pin_accept = 1'b0;
    check("t1_state_done", 32'(dut.state), 32'(DONE));
    press(ZERO);
    check("t1_done_hold_pin", 32'(bus.out_PIN), 32'hF);
    check("t1_done_key_ignored", 32'(dut.state), 32'(DONE));
    bus.in_card = 1'b0;
    tick(1);
    check("t1_state_idle", 32'(dut.state), 32'(IDLE));

    // CLEAR, fifth digit ignored, simultaneous accept/reject.
    bus.in_card = 1'b1;
    tick(1);
    enter_pin(4'b0101);
    check("t2_digit_cnt_a", 32'(bus.digit_cnt), 32'd4);
    press(CLEAR);
    check("t2_clear_cnt", 32'(bus.digit_cnt), 32'd0);
    check("t2_clear_state", 32'(dut.state), 32'(COLLECT));
    enter_pin(4'b1111);
    press(ZERO);
    check("t2_fifth_ignored", 32'(bus.digit_cnt), 32'd4);
    exp_q.push_back(4'b1111);
    press(ENTER);
    check("t2_out_PIN", 32'(bus.out_PIN), 32'hF);
    tick(1);
    bus.pin_accept = 1'b1;
    bus.pin_reject = 1'b1;
    tick(1);
    bus.pin_accept = 1'b0;
    bus.pin_reject = 1'b0;
    check("t2_accept_wins", 32'(dut.state), 32'(DONE));
    check("t2_try_unchanged", 32'(dut.try_cnt), 32'd0);
    bus.in_card = 1'b0;
    tick(1);

    // Short ENTER, CANCEL ejects, card pulled mid-entry does not.
    bus.in_card = 1'b1;
    tick(1);
    press(ONE);
    press(ZERO);
    press(ONE);
    press(ENTER);
    tick(1);
    check("t3_short_enter_state", 32'(dut.state), 32'(COLLECT));
    check("t3_short_enter_cnt", 32'(bus.digit_cnt), 32'd3);
    press(CANCEL);
    check("t3_cancel_eject", 32'(bus.eject_card), 32'd1);
    check("t3_cancel_state", 32'(dut.state), 32'(IDLE));
    tick(1);
    check("t3_eject_drop", 32'(bus.eject_card), 32'd0);
    press(ONE);
    press(ONE);
    e0 = eject_cnt;
    bus.in_card = 1'b0;
    tick(1);
    check("t3_pull_state", 32'(dut.state), 32'(IDLE));
    check("t3_pull_cnt", 32'(bus.digit_cnt), 32'd0);
    tick(1);
    check("t3_pull_no_eject", 32'(eject_cnt), 32'(e0));

    // Three rejections lock the card in; only reset releases it.
    bus.in_card = 1'b1;
    tick(1);
    e0 = eject_cnt;
    for (int i = 0; i < 3; i++) begin
      enter_pin(pins[i]);
      exp_q.push_back(pins[i]);
      press(ENTER);
      tick(1);
      bus.pin_reject = 1'b1;
      tick(1);
      bus.pin_reject = 1'b0;
      if (i < 2) begin
        check("t4_retry_state", 32'(dut.state), 32'(COLLECT));
        check("t4_retry_cnt", 32'(bus.digit_cnt), 32'd0);
        check("t4_retry_unlocked", 32'(bus.O_Lockout), 32'd0);
      end
    end
    check("t4_lockout", 32'(bus.O_Lockout), 32'd1);
    check("t4_locked_state", 32'(dut.state), 32'(LOCKED));
    bus.in_card = 1'b0;
    tick(3);
    press(CANCEL);
    check("t4_card_out_ignored", 32'(dut.state), 32'(LOCKED));
    check("t4_lockout_held", 32'(bus.O_Lockout), 32'd1);
    check("t4_no_eject", 32'(eject_cnt), 32'(e0));
    #2;
    rst = 1'b0;
    #1;
    check("t4_async_unlock", 32'(bus.O_Lockout), 32'd0);
    check("t4_async_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk_tb);
    #1;
    rst = 1'b1;

    // Inactivity timeout, then a key in the terminal cycle restarts the count.
    bus.in_card = 1'b1;
    tick(1);
    e0 = eject_cnt;
    tick(999);
    check("t5_no_timeout_yet", 32'(bus.O_Timeout), 32'd0);
    check("t5_still_collect", 32'(dut.state), 32'(COLLECT));
    tick(1);
    check("t5_timeout", 32'(bus.O_Timeout), 32'd1);
    check("t5_timeout_eject", 32'(bus.eject_card), 32'd1);
    check("t5_timeout_idle", 32'(dut.state), 32'(IDLE));
    tick(1);
    check("t5_timeout_drop", 32'(bus.O_Timeout), 32'd0);
    tick(999);
    check("t5_restart_pre", 32'(bus.O_Timeout), 32'd0);
    press(ONE);
    check("t5_key_saves", 32'(bus.O_Timeout), 32'd0);
    check("t5_key_state", 32'(dut.state), 32'(COLLECT));
    check("t5_key_digit", 32'(bus.digit_cnt), 32'd1);
    tick(999);
    check("t5_restart_no_timeout", 32'(bus.O_Timeout), 32'd0);
    tick(1);
    check("t5_restart_timeout", 32'(bus.O_Timeout), 32'd1);
    bus.in_card = 1'b0;
    tick(2);
    check("t5_timeout_count", 32'(tmo_cnt), 32'd2);
    check("t5_eject_count", 32'(eject_cnt - e0), 32'd2);

    // Asynchronous reset while awaiting a verdict.
    bus.in_card = 1'b1;
    tick(1);
    enter_pin(4'b0110);
    exp_q.push_back(4'b0110);
    press(ENTER);
    tick(1);
    check("t6_wait_state", 32'(dut.state), 32'(WAIT_RESULT));
    check("t6_wait_pin", 32'(bus.out_PIN), 32'h6);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_out_PIN", 32'(bus.out_PIN), 32'd0);
    check("t6_rst_digit_cnt", 32'(bus.digit_cnt), 32'd0);
    check("t6_rst_pin_valid", 32'(bus.pin_valid), 32'd0);
    check("t6_rst_lockout", 32'(bus.O_Lockout), 32'd0);
    check("t6_rst_timeout", 32'(bus.O_Timeout), 32'd0);
    check("t6_rst_eject", 32'(bus.eject_card), 32'd0);
    check("t6_rst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk_tb);
    #1;
    rst = 1'b1;
    bus.in_card = 1'b0;
    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/atm_pin_entry.md
ATM_PIN_ENTRY -- requirements
Module: atm_pin_entry

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles without a keypress before the session is abandoned.
REQ-002 The block SHALL have parameter MAX_TRIES, default 3, meaning rejected PIN entries allowed before lockout.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_card, input, 1 bit: card present (level).
REQ-006 The block SHALL have port key_valid, input, 1 bit: one-cycle keypress strobe.
REQ-007 The block SHALL have port key_code, input, 3 bits: 0=ZERO, 1=ONE, 2=CLEAR, 3=ENTER, 4=CANCEL; 5-7 ignored.
REQ-008 The block SHALL have port pin_accept, input, 1 bit: downstream ATM FSM accepted the PIN.
REQ-009 The block SHALL have port pin_reject, input, 1 bit: downstream ATM FSM rejected the PIN.
REQ-010 The block SHALL have port out_PIN, output, 4 bits: assembled PIN driven to the ATM FSM in_PIN.
REQ-011 The block SHALL have port pin_valid, output, 1 bit: one-cycle pulse, out_PIN ready.
REQ-012 The block SHALL have port digit_cnt, output, 3 bits: digits entered, 0-4.
REQ-013 The block SHALL have port O_Lockout, output, 1 bit: card retained, session locked.
REQ-014 The block SHALL have port O_Timeout, output, 1 bit: one-cycle pulse on inactivity timeout.
REQ-015 The block SHALL have port eject_card, output, 1 bit: one-cycle card-eject pulse.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, COLLECT, WAIT_RESULT, DONE and LOCKED.
REQ-017 IDLE: in_card=1 -> COLLECT, with the shift buffer, digit_cnt, try counter and idle counter all cleared.
REQ-018 COLLECT, ZERO/ONE key with digit_cnt<4: shift the buffer left, insert the key bit at LSB, digit_cnt+1; with digit_cnt=4 the key is ignored.
REQ-019 COLLECT, CLEAR key: buffer=0 and digit_cnt=0, state unchanged.
REQ-020 COLLECT, ENTER key with digit_cnt=4: out_PIN<=buffer, pin_valid=1 in the following cycle only, -> WAIT_RESULT; ENTER with digit_cnt<4 is ignored.
REQ-021 COLLECT, CANCEL key: eject_card pulse, -> IDLE.
REQ-022 Idle counter SHALL clear on every key_valid in COLLECT; counter reaching TIMEOUT_CYCLES-1 -> O_Timeout and eject_card pulse in the same cycle, -> IDLE.
REQ-023 WAIT_RESULT: key_valid ignored, idle counter frozen; pin_accept -> DONE.
REQ-024 WAIT_RESULT, pin_reject: try counter+1; if the new count = MAX_TRIES -> LOCKED, else -> COLLECT with buffer and digit_cnt cleared.
REQ-025 WAIT_RESULT, pin_accept and pin_reject asserted in the same cycle: accept SHALL win.
REQ-026 DONE: out_PIN held, keys ignored; in_card=0 -> IDLE.
REQ-027 LOCKED: O_Lockout=1, no eject, in_card and keys ignored; exit only by reset.
REQ-028 in_card=0 while in COLLECT or WAIT_RESULT -> IDLE next cycle, buffer cleared, no eject pulse.
REQ-029 A single key_valid SHALL cause at most one action.
REQ-030 pin_valid, O_Timeout and eject_card SHALL never be high for two consecutive cycles.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE with out_PIN=0, pin_valid=0, digit_cnt=0, O_Lockout=0, O_Timeout=0, eject_card=0, and all counters 0, including mid-session and in LOCKED.
REQ-032 The first state change after reset release SHALL occur on the first rising clk edge with rst=1.

Structure
REQ-033 Shared package atm_pin_pkg SHALL hold the state enum and the key_code constants ZERO/ONE/CLEAR/ENTER/CANCEL.
REQ-034 The inactivity counter SHALL be a sub-module named atm_timeout_counter with ports clear, enable and expired.

Verification
REQ-035 Card in; keys 1,1,1,1, ENTER -> pin_valid pulse one cycle after ENTER with out_PIN=4'b1111; pin_accept -> DONE; card out -> IDLE.
REQ-036 Keys 0,1,0,1, CLEAR, 1,1,1,1, ENTER -> out_PIN=4'b1111; a fifth digit before ENTER -> ignored, digit_cnt stays 4.
REQ-037 Three PIN entries each answered with pin_reject -> O_Lockout=1 after the third, no eject_card; card removal ignored; rst low -> O_Lockout=0.
REQ-038 Card in, no keys for TIMEOUT_CYCLES cycles -> O_Timeout and eject_card pulse together, state IDLE; a key at cycle 999 restarts the count.
REQ-039 pin_accept and pin_reject in the same cycle -> DONE, try counter unchanged; ENTER with 3 digits -> no pin_valid.
REQ-040 rst asserted in WAIT_RESULT between clock edges -> all outputs 0 immediately, without waiting for clk.
